// File: rtl/pc_sequencer.sv
// pc_sequencer: parametrised program-counter sequencer feeding the
// instruction-memory address port. Supports stall, absolute jump, signed
// relative branch and call/return through a hardware return-address stack.
//
// Ports:
//   sysclk      - system clock, all state updates on the rising edge
//   reset       - asynchronous active-high reset
//   stall       - hold pc and stack, drop every other request this cycle
//   jump        - load jump_addr
//   jump_addr   - absolute jump target
//   branch      - add branch_off (two's complement) to pc
//   branch_off  - relative branch offset
//   call        - push pc + STEP, load call_addr
//   call_addr   - call target
//   ret         - pop the return stack into pc
//   pc          - current program counter (registered)
//   stack_depth - number of valid return-stack entries
//   stack_full  - stack_depth == DEPTH
//   stack_empty - stack_depth == 0
//   overflow    - sticky: call seen while the stack was full
//   underflow   - sticky: ret seen while the stack was empty

// One return-stack register. Contents are don't-care after reset, so the
// entry carries no reset and only loads when the top level selects it.
module pc_stack_entry #(
    parameter int WIDTH = 8
) (
    input  logic             sysclk,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge sysclk) begin
        if (we) q <= d;
    end
endmodule

module pc_sequencer #(
    parameter int WIDTH     = 8,
    parameter int STEP      = 1,
    parameter int RESET_VEC = 0,
    parameter int DEPTH     = 4,
    localparam int DW       = $clog2(DEPTH + 1)
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             stall,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             branch,
    input  logic [WIDTH-1:0] branch_off,
    input  logic             call,
    input  logic [WIDTH-1:0] call_addr,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [DW-1:0]    stack_depth,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             overflow,
    output logic             underflow
);

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_RET,
        ACT_CALL,
        ACT_JUMP,
        ACT_BRANCH,
        ACT_STEP
    } act_e;

    logic [DW-1:0]                depth_q;
    logic [DEPTH-1:0][WIDTH-1:0]  stk;
    logic [WIDTH-1:0]             pc_inc;
    logic [WIDTH-1:0]             top;
    logic                         push;
    act_e                         act;

    assign stack_depth = depth_q;
    assign stack_full  = (depth_q == DW'(DEPTH));
    assign stack_empty = (depth_q == '0);

    // Sequential successor; also the return address pushed by a call.
    assign pc_inc = pc + WIDTH'(STEP);

    // Fixed-priority request decode; lower requests in the same cycle drop.
    always_comb begin
        act = ACT_STEP;
        if (stall)       act = ACT_HOLD;
        else if (ret)    act = ACT_RET;
        else if (call)   act = ACT_CALL;
        else if (jump)   act = ACT_JUMP;
        else if (branch) act = ACT_BRANCH;
    end

    // A call into a full stack still redirects pc but drops the push.
    assign push = (act == ACT_CALL) && !stack_full;

    // Top of stack is entry[depth-1]; a compare-select avoids indexing the
    // array with a pointer wider than the entry count.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) top = stk[i];
        end
    end

    // Write pointer equals the current depth, so a push fills entry[depth].
    for (genvar i = 0; i < DEPTH; i++) begin : g_stk
        pc_stack_entry #(.WIDTH(WIDTH)) u_ent (
            .sysclk (sysclk),
            .we     (push && (depth_q == DW'(i))),
            .d      (pc_inc),
            .q      (stk[i])
        );
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            pc        <= WIDTH'(RESET_VEC);
            depth_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (act)
                ACT_HOLD: ;
                ACT_RET: begin
                    if (stack_empty) begin
                        underflow <= 1'b1;
                        pc        <= pc_inc;
                    end else begin
                        pc      <= top;
                        depth_q <= depth_q - DW'(1);
                    end
                end
                ACT_CALL: begin
                    pc <= call_addr;
                    if (stack_full) overflow <= 1'b1;
                    else            depth_q  <= depth_q + DW'(1);
                end
                ACT_JUMP:   pc <= jump_addr;
                // Two's-complement add; the truncated sum handles negative offsets.
                ACT_BRANCH: pc <= pc + branch_off;
                default:    pc <= pc_inc;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    logic       stall = 0, jump = 0, branch = 0, call = 0, ret = 0;
    logic [7:0] jump_addr = 0, branch_off = 0, call_addr = 0;
    logic [7:0] pc;
    logic [2:0] stack_depth;
    logic       stack_full, stack_empty, overflow, underflow;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    pc_sequencer #(.WIDTH(8), .STEP(1), .RESET_VEC(0), .DEPTH(4)) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .stall       (stall),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .branch      (branch),
        .branch_off  (branch_off),
        .call        (call),
        .call_addr   (call_addr),
        .ret         (ret),
        .pc          (pc),
        .stack_depth (stack_depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 sysclk = ~sysclk;

    // Reference model: integer pc, a queue as the return stack, two flags.
    int m_pc  = 0;
    int m_stk[$];
    bit m_ovf = 0, m_udf = 0;

    always @(posedge sysclk or posedge reset) begin
        if (reset) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 0;
            m_udf = 0;
        end else if (stall) begin
        end else if (ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_udf = 1; m_pc = (m_pc + 1) % 256; end
        end else if (call) begin
            if (m_stk.size() < 4) m_stk.push_back((m_pc + 1) % 256);
            else m_ovf = 1;
            m_pc = int'(call_addr);
        end else if (jump) begin
            m_pc = int'(jump_addr);
        end else if (branch) begin
            m_pc = (m_pc + int'($signed(branch_off)) + 256) % 256;
        end else begin
            m_pc = (m_pc + 1) % 256;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge sysclk) begin
        if (chk_en) begin
            chk("model.pc",    int'(pc),          m_pc);
            chk("model.depth", int'(stack_depth), m_stk.size());
            chk("model.full",  int'(stack_full),  int'(m_stk.size() == 4));
            chk("model.empty", int'(stack_empty), int'(m_stk.size() == 0));
            chk("model.ovf",   int'(overflow),    int'(m_ovf));
            chk("model.udf",   int'(underflow),   int'(m_udf));
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle();
        stall = 0; jump = 0; branch = 0; call = 0; ret = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        #1 reset = 1;
        chk_en = 1;
        @(negedge sysclk);
        #1;
        chk("reset.pc", int'(pc), 8'h00);
        chk("reset.empty", int'(stack_empty), 1);
        @(posedge sysclk);
        #1 reset = 0;

        // Free-running count and wrap.
        for (int e = 1; e <= 260; e++) begin
            tick();
            if (e == 1)   chk("wrap.e1",   int'(pc), 8'h01);
            if (e == 255) chk("wrap.e255", int'(pc), 8'hFF);
            if (e == 256) chk("wrap.e256", int'(pc), 8'h00);
            if (e == 260) chk("wrap.e260", int'(pc), 8'h04);
        end
        // Asynchronous reset mid-cycle.
        #2 reset = 1;
        #1 chk("async.reset.pc", int'(pc), 8'h00);
        @(posedge sysclk);
        #1 reset = 0;

        // Jump, branch, stall.
        for (int e = 0; e < 16; e++) tick();
        chk("pre.jump.pc", int'(pc), 8'h10);
        jump = 1; jump_addr = 8'h80; tick(); chk("jump.pc", int'(pc), 8'h80);
        idle(); branch = 1; branch_off = 8'hFC; tick(); chk("branch.neg", int'(pc), 8'h7C);
        idle(); stall = 1;
        for (int e = 0; e < 3; e++) begin tick(); chk("stall.hold", int'(pc), 8'h7C); end
        idle(); tick(); chk("post.stall", int'(pc), 8'h7D);
        jump = 1; branch = 1; jump_addr = 8'h40; branch_off = 8'h10;
        tick(); chk("jump.over.branch", int'(pc), 8'h40);
        idle(); branch = 1; branch_off = 8'h7F; tick(); chk("branch.pos", int'(pc), 8'hBF);

        // Call/return nesting.
        idle(); jump = 1; jump_addr = 8'h05; tick();
        idle(); call = 1; call_addr = 8'h20; tick();
        chk("call1.pc", int'(pc), 8'h20);
        call_addr = 8'h30; tick();
        chk("call2.pc", int'(pc), 8'h30);
        chk("call2.depth", int'(stack_depth), 2);
        idle(); ret = 1; tick();
        chk("ret1.pc", int'(pc), 8'h21);
        chk("ret1.depth", int'(stack_depth), 1);
        tick();
        chk("ret2.pc", int'(pc), 8'h06);
        chk("ret2.empty", int'(stack_empty), 1);

        // Overflow: pushes 0x07, 0xA1, 0xA2, 0xA3; fifth push dropped.
        idle(); call = 1;
        for (int k = 0; k < 5; k++) begin
            call_addr = 8'(8'hA0 + k);
            tick();
            if (k == 3) begin
                chk("ovf.full4", int'(stack_full), 1);
                chk("ovf.flag4", int'(overflow), 0);
            end
        end
        chk("ovf.pc5", int'(pc), 8'hA4);
        chk("ovf.flag5", int'(overflow), 1);
        chk("ovf.depth5", int'(stack_depth), 4);
        idle(); ret = 1;
        tick(); chk("ovf.ret1", int'(pc), 8'hA3);
        tick(); chk("ovf.ret2", int'(pc), 8'hA2);
        tick(); chk("ovf.ret3", int'(pc), 8'hA1);
        tick(); chk("ovf.ret4", int'(pc), 8'h07);
        chk("ovf.sticky", int'(overflow), 1);
        idle(); do_reset();
        chk("ovf.cleared", int'(overflow), 0);

        // Underflow, then call+ret priority.
        jump = 1; jump_addr = 8'h50; tick();
        idle(); ret = 1; tick();
        chk("udf.pc", int'(pc), 8'h51);
        chk("udf.flag", int'(underflow), 1);
        chk("udf.depth", int'(stack_depth), 0);
        idle(); call = 1; call_addr = 8'h60; tick();
        call_addr = 8'h70; ret = 1; tick();
        chk("ret.over.call.pc", int'(pc), 8'h52);
        chk("ret.over.call.depth", int'(stack_depth), 0);

        // Stall beats everything.
        idle(); call = 1; call_addr = 8'h33; tick();
        stall = 1; call = 1; ret = 1; jump = 1; branch = 1;
        call_addr = 8'h99; jump_addr = 8'h88; branch_off = 8'h04;
        tick();
        chk("stall.all.pc", int'(pc), 8'h33);
        chk("stall.all.depth", int'(stack_depth), 1);
        chk("stall.all.udf", int'(underflow), 1);
        chk("stall.all.ovf", int'(overflow), 0);
        idle(); tick();
        chk("post.stall.all", int'(pc), 8'h34);

        @(negedge sysclk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
